hazard_ctrl: RTL



---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_sat_counter.sv | 21 ++
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WAIT_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        FREEZE = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
// Latency: count reflects inc one cycle later.
// Backpressure: none, counts every cycle inc is high.
module hazard_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush producer for IF/ID, ID/EX, EX/MEM and PC: load-use bubbles, redirect flushes, dmem freeze + watchdog.
// Latency: stall/flush outputs are Mealy (same cycle); mem_timeout and perf counters are registered.
// Backpressure: dmem_busy freezes every stage; perf counters exist only with HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REDIRECT_FLUSH_CYCLES = 1,
    parameter int MAX_MEM_WAIT          = 64,
    parameter int PERF_CNT_W            = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_mem_read_en,
    input  logic                  ex_redirect,
    input  logic                  dmem_busy,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_flush,
    output logic                  ex_mem_stall,
    output logic                  mem_timeout,
    output logic [PERF_CNT_W-1:0] perf_lu_cnt,
    output logic [PERF_CNT_W-1:0] perf_flush_cnt,
    output logic [PERF_CNT_W-1:0] perf_freeze_cnt
);

    localparam logic [2:0]            FLUSH_RELOAD = 3'(REDIRECT_FLUSH_CYCLES - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT   = WAIT_CNT_W'(MAX_MEM_WAIT - 1);

    state_t                state, state_nxt, eff_state;
    logic [2:0]            flush_left, flush_left_nxt;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  load_use;
    logic pc_stall_raw, if_id_stall_raw, if_id_flush_raw;
    logic id_ex_stall_raw, id_ex_flush_raw, ex_mem_stall_raw;

    assign load_use = ex_mem_read_en && (ex_rd_addr != '0) &&
                      ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                       (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

    // Leaving FREEZE is decided in the release cycle itself, so that cycle behaves as FLUSH or RUN.
    assign eff_state = (state == FREEZE) ? ((flush_left != 3'd0) ? FLUSH : RUN) : state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            flush_left <= 3'd0;
        end else begin
            state      <= state_nxt;
            flush_left <= flush_left_nxt;
        end
    end

    always_comb begin
        state_nxt      = RUN;
        flush_left_nxt = flush_left;
        if (dmem_busy) begin
            state_nxt = FREEZE;
        end else if (ex_redirect) begin
            flush_left_nxt = FLUSH_RELOAD;
            state_nxt      = (FLUSH_RELOAD != 3'd0) ? FLUSH : RUN;
        end else if (eff_state == FLUSH) begin
            flush_left_nxt = flush_left - 3'd1;
            state_nxt      = (flush_left == 3'd1) ? RUN : FLUSH;
        end
    end

    always_comb begin
        pc_stall_raw     = 1'b0;
        if_id_stall_raw  = 1'b0;
        if_id_flush_raw  = 1'b0;
        id_ex_stall_raw  = 1'b0;
        id_ex_flush_raw  = 1'b0;
        ex_mem_stall_raw = 1'b0;
        if (dmem_busy) begin
            pc_stall_raw     = 1'b1;
            if_id_stall_raw  = 1'b1;
            id_ex_stall_raw  = 1'b1;
            ex_mem_stall_raw = 1'b1;
        end else if (ex_redirect || (eff_state == FLUSH)) begin
            if_id_flush_raw = 1'b1;
            id_ex_flush_raw = 1'b1;
        end else if (load_use) begin
            pc_stall_raw    = 1'b1;
            if_id_stall_raw = 1'b1;
            id_ex_flush_raw = 1'b1;
        end
    end

    assign pc_stall     = pc_stall_raw     & rst_n;
    assign if_id_stall  = if_id_stall_raw  & rst_n;
    assign if_id_flush  = if_id_flush_raw  & rst_n;
    assign id_ex_stall  = id_ex_stall_raw  & rst_n;
    assign id_ex_flush  = id_ex_flush_raw  & rst_n;
    assign ex_mem_stall = ex_mem_stall_raw & rst_n;

    // Watchdog counts every busy cycle, including the one that entered FREEZE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (dmem_busy) begin
            if (wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (wait_cnt == WAIT_LIMIT) begin
                mem_timeout <= 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic lu_bubble;
    // id_ex_flush without if_id_flush only happens for a load-use bubble.
    assign lu_bubble = id_ex_flush & ~if_id_flush;

    hazard_sat_counter #(.W(PERF_CNT_W)) u_lu_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (lu_bubble),
        .count (perf_lu_cnt)
    );

    hazard_sat_counter #(.W(PERF_CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (if_id_flush),
        .count (perf_flush_cnt)
    );

    hazard_sat_counter #(.W(PERF_CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ex_mem_stall),
        .count (perf_freeze_cnt)
    );
`else
    assign perf_lu_cnt     = '0;
    assign perf_flush_cnt  = '0;
    assign perf_freeze_cnt = '0;
`endif

endmodule
